// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared light codes, sensor FSM states and detector timing defaults
package tlc_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PRES,
        HOLD
    } sense_state_t;

    localparam int DEB_CYCLES_DEF  = 4;
    localparam int HOLD_CYCLES_DEF = 8;

    // Counter must hold the larger of the two thresholds without wrapping.
    function automatic int cnt_width(input int deb, input int hold);
        return $clog2(((deb > hold) ? deb : hold) + 1);
    endfunction

endpackage

// File: rtl/tlc_sense_chan.sv
// rtl/tlc_sense_chan.sv - one detector lane: synchroniser, debounce/hold FSM and request latch
import tlc_pkg::*;

module tlc_sense_chan #(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw,
    input  logic [1:0] light,
    output logic       pres,
    output logic       req
);

    localparam int CW = cnt_width(DEB_CYCLES, HOLD_CYCLES);

    logic          sync_1;
    logic          sync_2;
    sense_state_t  state;
    logic [CW-1:0] cnt;
    logic          is_green;

    assign pres     = (state == PRES) || (state == HOLD);
    assign is_green = (light == GREEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            req    <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;

            // A car seen while the lane is not green must be served later.
            if (is_green) begin
                req <= 1'b0;
            end else if (pres) begin
                req <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sync_2) begin
                        state <= ARM;
                        cnt   <= CW'(1);
                    end
                end
                ARM: begin
                    if (!sync_2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt + CW'(1) == CW'(DEB_CYCLES)) begin
                        state <= PRES;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PRES: begin
                    if (!sync_2) begin
                        state <= HOLD;
                        cnt   <= CW'(1);
                    end
                end
                HOLD: begin
                    if (sync_2) begin
                        state <= PRES;
                        cnt   <= '0;
                    end else if (cnt == CW'(HOLD_CYCLES)) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/tlc_sensor_cond.sv
// rtl/tlc_sensor_cond.sv - two-lane detector conditioning producing Ta/Tb for the light controller
import tlc_pkg::*;

module tlc_sensor_cond #(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sa_raw,
    input  logic       sb_raw,
    input  logic [1:0] La,
    input  logic [1:0] Lb,
    output logic       Ta,
    output logic       Tb,
    output logic       pres_a,
    output logic       pres_b
);

    logic req_a;
    logic req_b;

    tlc_sense_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .reset (reset),
        .raw   (sa_raw),
        .light (La),
        .pres  (pres_a),
        .req   (req_a)
    );

    tlc_sense_chan #(
        .DEB_CYCLES  (DEB_CYCLES),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .reset (reset),
        .raw   (sb_raw),
        .light (Lb),
        .pres  (pres_b),
        .req   (req_b)
    );

    // Both terms are flop outputs, so La/Lb and the raw inputs never reach Ta/Tb combinationally.
    assign Ta = pres_a | req_a;
    assign Tb = pres_b | req_b;

endmodule

// File: tb/tb_tlc_sensor_cond.sv
// tb/tb_tlc_sensor_cond.sv - self-checking bench for tlc_sensor_cond with a run-length presence model
module tb_tlc_sensor_cond;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sa_raw;
    logic       sb_raw;
    logic [1:0] La;
    logic [1:0] Lb;
    logic       Ta;
    logic       Tb;
    logic       pres_a;
    logic       pres_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Model: raw samples of the last two edges, consecutive-run lengths, presence and request.
    bit p1 [2];
    bit p2 [2];
    int hi_run [2];
    int lo_run [2];
    bit pres_m [2];
    bit req_m [2];

    always #5 clk = ~clk;

    tlc_sensor_cond #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sa_raw (sa_raw),
        .sb_raw (sb_raw),
        .La     (La),
        .Lb     (Lb),
        .Ta     (Ta),
        .Tb     (Tb),
        .pres_a (pres_a),
        .pres_b (pres_b)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit v;
        bit was_pres;
        bit raw;
        logic [1:0] lt;
        for (int l = 0; l < 2; l++) begin
            raw = (l == 0) ? sa_raw : sb_raw;
            lt  = (l == 0) ? La : Lb;
            if (reset) begin
                p1[l] = 0; p2[l] = 0; hi_run[l] = 0; lo_run[l] = 0;
                pres_m[l] = 0; req_m[l] = 0;
            end else begin
                v = p2[l];
                was_pres = pres_m[l];
                if (lt == 2'b00) req_m[l] = 0;
                else if (was_pres) req_m[l] = 1;
                if (v) begin
                    hi_run[l] = (hi_run[l] < 1000) ? hi_run[l] + 1 : hi_run[l];
                    lo_run[l] = 0;
                end else begin
                    lo_run[l] = (lo_run[l] < 1000) ? lo_run[l] + 1 : lo_run[l];
                    hi_run[l] = 0;
                end
                // Presence needs DEB highs in a row; it survives up to HOLD lows in a row.
                if (!was_pres && hi_run[l] >= DEB) pres_m[l] = 1;
                else if (was_pres && lo_run[l] > HOLD) pres_m[l] = 0;
                p2[l] = p1[l];
                p1[l] = raw;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("model_pres_a", pres_a, pres_m[0]);
            chk("model_pres_b", pres_b, pres_m[1]);
            chk("model_ta", Ta, pres_m[0] | req_m[0]);
            chk("model_tb", Tb, pres_m[1] | req_m[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ta"}, Ta, 1'b0);
        chk({name, "_tb"}, Tb, 1'b0);
        chk({name, "_pres_a"}, pres_a, 1'b0);
        chk({name, "_pres_b"}, pres_b, 1'b0);
    endtask

    initial begin
        reset = 1'b1; sa_raw = 1'b1; sb_raw = 1'b1; La = 2'b10; Lb = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            cmp_en = 1'b1;
            chk_all_zero("reset_hold");
        end
        reset = 1'b0;
        step();
        chk_all_zero("reset_release");
        sa_raw = 1'b0; sb_raw = 1'b0;
        repeat (12) step();

        // Clean arrival with lane A red.
        sa_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) chk("arrive_edge5_pres_a", pres_a, 1'b0);
        end
        chk("arrive_edge6_pres_a", pres_a, 1'b1);
        chk("arrive_edge6_ta", Ta, 1'b1);
        chk("arrive_edge6_tb", Tb, 1'b0);

        // Short dropout is bridged.
        sa_raw = 1'b0;
        repeat (5) begin step(); chk("dropout_low_pres_a", pres_a, 1'b1); end
        sa_raw = 1'b1;
        repeat (6) begin step(); chk("dropout_high_pres_a", pres_a, 1'b1); end

        // Long release: pres falls after edge k+10, request keeps Ta up while red.
        sa_raw = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 10) chk("release_edge10_pres_a", pres_a, 1'b1);
            if (i == 11) chk("release_edge11_pres_a", pres_a, 1'b0);
            if (i == 12) chk("release_req_ta", Ta, 1'b1);
        end
        La = 2'b00;
        step();
        chk("green_clears_ta", Ta, 1'b0);

        // Glitch of 3 samples never asserts presence.
        La = 2'b10;
        sa_raw = 1'b1;
        repeat (3) step();
        sa_raw = 1'b0;
        repeat (12) begin
            step();
            chk("glitch_pres_a", pres_a, 1'b0);
            chk("glitch_ta", Ta, 1'b0);
        end
        // Full debounce latency again shows the channel went back to idle.
        sa_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (i == 5) chk("reidle_edge5_pres_a", pres_a, 1'b0);
        end
        chk("reidle_edge6_pres_a", pres_a, 1'b1);
        sa_raw = 1'b0;
        repeat (12) step();
        La = 2'b00;
        step();
        chk("reidle_cleared_ta", Ta, 1'b0);

        // Green throughout: Ta tracks pres only.
        sa_raw = 1'b1;
        repeat (6) step();
        chk("green_pres_a", pres_a, 1'b1);
        sa_raw = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 10) chk("green_edge10_ta", Ta, 1'b1);
            if (i == 11) begin
                chk("green_edge11_pres_a", pres_a, 1'b0);
                chk("green_edge11_ta", Ta, 1'b0);
            end
        end

        // Both lanes, B staggered by two edges; Lb=11 behaves as red.
        La = 2'b10; Lb = 2'b11;
        sa_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 2) sb_raw = 1'b1;
            if (i == 6) begin
                chk("stagger_edge6_pres_a", pres_a, 1'b1);
                chk("stagger_edge6_pres_b", pres_b, 1'b0);
            end
            if (i == 7) chk("stagger_edge7_pres_b", pres_b, 1'b0);
            if (i == 8) chk("stagger_edge8_pres_b", pres_b, 1'b1);
        end
        sa_raw = 1'b0;
        repeat (4) step();
        chk("hold_pres_a", pres_a, 1'b1);
        chk("hold_ta", Ta, 1'b1);
        chk("hold_tb", Tb, 1'b1);

        // Reset while lane A sits in HOLD with its request set.
        reset = 1'b1;
        step();
        chk_all_zero("midreset_edge1");
        step();
        chk_all_zero("midreset_edge2");
        sb_raw = 1'b0;
        reset = 1'b0;
        repeat (3) begin step(); chk_all_zero("post_reset"); end
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
